// File: rtl/rv_pkg.sv
// Shared rv32i front-end types and constants used by fetch and decode.
package rv_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'd0;
  localparam logic [XLEN-1:0] NOP_IR   = 32'h0000_0000;

  // Major opcode and shift funct3 encodings shared with decode
  localparam logic [6:0] OPC_AR       = 7'b0110011;
  localparam logic [6:0] OPC_AR_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_M_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_M_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BR       = 7'b1100011;
  localparam logic [2:0] F3_SH_LEFT   = 3'b001;
  localparam logic [2:0] F3_SH_RIGHT  = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Word-indexed PC increment; wraps silently at 2^32
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/rv_fetch_queue_chk.sv
// Occupancy invariants of the fetch queue's instruction and tag FIFOs.
module rv_fetch_queue_chk #(
  parameter int TCW = 2,
  parameter int OW  = 2
) (
  input logic           clk,
  input logic           rst,
  input logic           ififo_push,
  input logic           ififo_pop,
  input logic           ififo_full,
  input logic           tag_push,
  input logic           tag_pop,
  input logic           tag_full,
  input logic           tag_empty,
  input logic [TCW-1:0] tag_count,
  input logic [OW-1:0]  outst
);

  a_ififo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(ififo_push && ififo_full && !ififo_pop));

  a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(tag_push && tag_full));

  a_tag_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(tag_pop && tag_empty));

  a_tag_within_outst: assert property (@(posedge clk) disable iff (rst)
    int'(tag_count) <= int'(outst));

endmodule

// File: rtl/rv_sync_fifo.sv
// Synchronous FIFO with flush; push while full is accepted only alongside a pop.
module rv_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push_s && !flush && !rst) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/rv_fetch_queue.sv
// Fetch front end: credit-limited imem requests, prefetch FIFO, redirect flush/drop.
// Optional same-cycle response-to-decode bypass when RV_FETCH_BYPASS_EN is defined.
module rv_fetch_queue
  import rv_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = rv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            RN,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_ir,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_npc
);

  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int FCW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [OW-1:0]   outst_r, outst_nxt_s;
  logic [OW-1:0]   drop_cnt_r, drop_cnt_nxt_s;
  logic            req_valid_s, req_fire_s, rsp_keep_s, byp_s, out_valid_s;
  logic            ififo_push_s, ififo_pop_s, ififo_full_s, ififo_empty_s;
  logic [FCW-1:0]  ififo_count_s;
  fetch_entry_t    ififo_wdata_s, ififo_rdata_s, head_s;
  logic            tag_full_s, tag_empty_s;
  logic [OW-1:0]   tag_count_s;
  logic [XLEN-1:0] tag_pc_s;

  // In-flight requests reserve FIFO slots so a response can never overflow it
  assign req_valid_s = !RN && !redirect_valid
                       && ((int'(ififo_count_s) + int'(outst_r)) < DEPTH)
                       && (int'(outst_r) < MAX_OUTST);
  assign req_fire_s  = req_valid_s && imem_req_ready;
  assign rsp_keep_s  = imem_rsp_valid && (drop_cnt_r == {OW{1'b0}})
                       && !redirect_valid && !RN;

`ifdef RV_FETCH_BYPASS_EN
  assign byp_s = rsp_keep_s && ififo_empty_s;
`else
  assign byp_s = 1'b0;
`endif

  assign ififo_wdata_s = '{ir: imem_rsp_data, pc: tag_pc_s};
  assign head_s        = byp_s ? ififo_wdata_s : ififo_rdata_s;
  assign out_valid_s   = !RN && (!ififo_empty_s || byp_s);
  assign ififo_push_s  = rsp_keep_s && !(byp_s && out_ready);
  assign ififo_pop_s   = !ififo_empty_s && out_ready && !redirect_valid;

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_r;
  assign out_valid      = out_valid_s;
  assign out_ir         = out_valid_s ? head_s.ir : NOP_IR;
  assign out_pc         = out_valid_s ? head_s.pc : 32'd0;
  assign out_npc        = out_valid_s ? pc_next(head_s.pc) : 32'd0;

  // Next fetch PC, outstanding count and wrong-path drop count
  always_comb begin
    outst_nxt_s    = outst_r + OW'(req_fire_s) - OW'(imem_rsp_valid);
    drop_cnt_nxt_s = drop_cnt_r;
    fetch_pc_nxt_s = fetch_pc_r;
    if (redirect_valid) begin
      drop_cnt_nxt_s = outst_nxt_s;
      fetch_pc_nxt_s = redirect_pc;
    end else begin
      if (imem_rsp_valid && (drop_cnt_r != {OW{1'b0}})) begin
        drop_cnt_nxt_s = drop_cnt_r - OW'(1);
      end else begin
        drop_cnt_nxt_s = drop_cnt_r;
      end
      if (req_fire_s) begin
        fetch_pc_nxt_s = pc_next(fetch_pc_r);
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
    end
  end

  // Fetch state registers
  always_ff @(posedge clk) begin
    if (RN) begin
      fetch_pc_r <= RESET_PC;
      outst_r    <= {OW{1'b0}};
      drop_cnt_r <= {OW{1'b0}};
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      outst_r    <= outst_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  rv_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_ififo (
    .clk   (clk),
    .rst   (RN),
    .flush (redirect_valid),
    .push  (ififo_push_s),
    .pop   (ififo_pop_s),
    .wdata (ififo_wdata_s),
    .rdata (ififo_rdata_s),
    .count (ififo_count_s),
    .full  (ififo_full_s),
    .empty (ififo_empty_s)
  );

  // Issued PCs in order; popped only by responses that are kept
  rv_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk   (clk),
    .rst   (RN),
    .flush (redirect_valid),
    .push  (req_fire_s),
    .pop   (rsp_keep_s),
    .wdata (fetch_pc_r),
    .rdata (tag_pc_s),
    .count (tag_count_s),
    .full  (tag_full_s),
    .empty (tag_empty_s)
  );

  rv_fetch_queue_chk #(.TCW(OW), .OW(OW)) u_chk (
    .clk        (clk),
    .rst        (RN),
    .ififo_push (ififo_push_s),
    .ififo_pop  (ififo_pop_s),
    .ififo_full (ififo_full_s),
    .tag_push   (req_fire_s),
    .tag_pop    (rsp_keep_s),
    .tag_full   (tag_full_s),
    .tag_empty  (tag_empty_s),
    .tag_count  (tag_count_s),
    .outst      (outst_r)
  );

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Scoreboard bench for rv_fetch_queue with a variable-latency in-order imem model.
module tb_rv_fetch_queue;

  logic        clk = 1'b0;
  logic        RN, redirect_valid, imem_req_ready, imem_rsp_valid, out_ready;
  logic [31:0] redirect_pc, imem_rsp_data;
  logic        imem_req_valid, out_valid;
  logic [31:0] imem_req_addr, out_ir, out_pc, out_npc;

  rv_fetch_queue #(.DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'd0)) dut (
    .clk(clk), .RN(RN), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_pc(out_pc), .out_npc(out_npc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] ir; logic [31:0] pc; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] seen_pc[$];
  logic [31:0] seen_npc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock: log the request handshake, advance, then present due responses
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    pend_t       p;
    #1;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    if (redirect_valid || RN) exp_q.delete();
    if (acc) begin
      acc_log.push_back(a);
      exp_q.push_back('{mem_word(a), a});
    end
    @(posedge clk);
    cyc++;
    if (RN) pend_q.delete();
    else if (acc) pend_q.push_back('{a, cyc + lat - 1});
    @(negedge clk);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(p.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
    end
  endtask

  task automatic do_reset();
    RN = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_ir", out_ir, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_npc", out_npc, 32'd0);
    exp_q.delete();
    acc_log.delete();
    seen_pc.delete();
    seen_npc.delete();
    RN = 1'b0;
  endtask

  // Monitor: sampled just before each active edge, pops on every accepted handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!RN && !redirect_valid && out_valid && out_ready) begin
        seen_pc.push_back(out_pc);
        seen_npc.push_back(out_npc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual_pc=%h required=none", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_ir", out_ir, e.ir);
          check("sb_pc", out_pc, e.pc);
          check("sb_npc", out_npc, e.pc + 32'd1);
        end
      end
    end
  end

  initial begin
    int  base;
    bit  found;
    bit  bad;
    RN = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; out_ready = 1'b0;
    @(negedge clk);

    // Streaming at one instruction per cycle
    do_reset();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 8; i++) check($sformatf("stream_addr%0d", i), qget(acc_log, i), 32'(i));
    check("stream_pops", {31'd0, seen_pc.size() >= 10}, 32'd1);
    for (int i = 0; i < 10; i++) check($sformatf("stream_pc%0d", i), qget(seen_pc, i), 32'(i));
    check("stream_npc0", qget(seen_npc, 0), 32'd1);

    // Back-pressure stops at DEPTH, then drains in order
    do_reset();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
    repeat (10) tick();
    #1;
    check("bp_req_count", 32'(acc_log.size()), 32'd4);
    check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("bp_no_pop", 32'(seen_pc.size()), 32'd0);
    out_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) check($sformatf("bp_pc%0d", i), qget(seen_pc, i), 32'(i));
    check("bp_resume_addr", qget(acc_log, 4), 32'd4);

    // Redirect with two requests in flight: both responses dropped
    do_reset();
    lat = 3; imem_req_ready = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'd10;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    for (int i = 0; i < 10 && acc_log.size() < 2; i++) tick();
    check("rd_issued", 32'(acc_log.size()), 32'd2);
    check("rd_addr10", qget(acc_log, 0), 32'd10);
    check("rd_addr11", qget(acc_log, 1), 32'd11);
    redirect_valid = 1'b1; redirect_pc = 32'd25;
    #1;
    check("rd_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();
    check("rd_first_pc", qget(seen_pc, 0), 32'd25);
    bad = 1'b0;
    foreach (seen_pc[i]) if (seen_pc[i] == 32'd10 || seen_pc[i] == 32'd11) bad = 1'b1;
    check("rd_no_wrong_path", {31'd0, bad}, 32'd0);
    check("rd_next_addr", qget(acc_log, 2), 32'd25);

    // Redirect coinciding with a response and a pop
    do_reset();
    lat = 2; imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      #1;
      found = imem_rsp_valid && out_valid;
    end
    check("rc_setup", {31'd0, found}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'd40;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rc_flushed", {31'd0, out_valid}, 32'd0);
    base = seen_pc.size();
    repeat (10) tick();
    check("rc_first_pc", qget(seen_pc, base), 32'd40);
    check("rc_second_pc", qget(seen_pc, base + 1), 32'd41);

    // PC wrap at 2^32
    do_reset();
    lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    repeat (6) tick();
    check("wrap_addr0", qget(acc_log, 0), 32'hFFFF_FFFF);
    check("wrap_addr1", qget(acc_log, 1), 32'd0);
    check("wrap_pc0", qget(seen_pc, 0), 32'hFFFF_FFFF);
    check("wrap_npc0", qget(seen_npc, 0), 32'd0);

    // Reset mid-stream with buffered and outstanding work
    do_reset();
    lat = 3; imem_req_ready = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 20 && acc_log.size() < 4; i++) tick();
    check("mr_setup", 32'(acc_log.size()), 32'd4);
    RN = 1'b1;
    tick();
    RN = 1'b0;
    acc_log.delete();
    seen_pc.delete();
    #1;
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    lat = 1; out_ready = 1'b1;
    repeat (8) tick();
    check("mr_first_addr", qget(acc_log, 0), 32'd0);
    check("mr_second_addr", qget(acc_log, 1), 32'd1);
    check("mr_first_pc", qget(seen_pc, 0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
